divider_iter: RTL
=================

DIVIDER_ITER -- requirements
Module: divider_iter

Interface
REQ-001 The block SHALL have parameter BITS, default 16, meaning operand/result width; legal range 2..64.
REQ-002 Port in_clk SHALL be an input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port in_rst SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port in_start SHALL be an input, 1 bit: start request, sampled in IDLE/DONE only.
REQ-005 Port in_signed SHALL be an input, 1 bit: 1 selects two's-complement operands, 0 selects unsigned; sampled with in_start.
REQ-006 Ports in_a and in_b SHALL be inputs, BITS each: dividend and divisor, sampled with in_start.
REQ-007 Port out_busy SHALL be an output, 1 bit: high in ITER and FIXUP.
REQ-008 Port out_finished SHALL be an output, 1 bit: high in DONE.
REQ-009 Ports out_quot and out_rem SHALL be outputs, BITS each: registered quotient and remainder.
REQ-010 Port out_divzero SHALL be an output, 1 bit: last result came from division by zero.

Function
REQ-011 The FSM SHALL have states IDLE, ITER, FIXUP and DONE.
REQ-012 In IDLE or DONE, a rising edge with in_start=1 SHALL latch operands and mode, clear out_finished and out_divzero, and enter ITER (or DONE per REQ-016).
REQ-013 On entry to ITER, the working dividend/divisor SHALL be the magnitudes of in_a/in_b (signed mode) or the raw values (unsigned), and the result signs SHALL be stored: quotient sign = sign(a) XOR sign(b), remainder sign = sign(a).
REQ-014 ITER SHALL run exactly BITS cycles of restoring radix-2 division, one quotient bit per cycle, MSB first, with a BITS+1-bit partial remainder and no overflow.
REQ-015 FIXUP SHALL negate quotient and/or remainder per the stored signs, write out_quot/out_rem, and enter DONE; total latency from start edge to out_finished high = BITS+2 edges.
REQ-016 If in_b==0 at start, the block SHALL skip ITER and enter DONE on that edge with out_quot = all ones, out_rem = in_a and out_divzero = 1 (latency 1 edge), in both modes.
REQ-017 Signed results SHALL truncate toward zero; most-negative / -1 SHALL give out_quot = most-negative (wrap) and out_rem = 0, with no flag.
REQ-018 in_start while out_busy SHALL be ignored; the running operation SHALL be unaffected.
REQ-019 out_quot/out_rem/out_divzero SHALL hold their last written value until the next FIXUP or divide-by-zero entry; intermediate iteration values SHALL NOT appear on them.
REQ-020 DONE SHALL persist until a new in_start; a start in DONE SHALL behave exactly as in IDLE.

Reset
REQ-021 in_rst=0 SHALL asynchronously force state IDLE, out_busy=0, out_finished=0, out_divzero=0, out_quot=0, out_rem=0, and clear all working registers, including mid-operation.
REQ-022 The first start SHALL be accepted on the first rising edge after in_rst returns high.

Configuration
REQ-023 With macro DIVIDER_ITER_SIGNED_EN defined, in_signed SHALL behave per REQ-005/013/017.
REQ-024 Without DIVIDER_ITER_SIGNED_EN, in_signed SHALL be present but ignored, all operations SHALL be unsigned, and no sign/negate logic SHALL be synthesised; latency SHALL be unchanged (FIXUP retained as a pure write stage).

Verification
REQ-025 BITS=16, unsigned, a=500, b=123, start one cycle -> out_finished high 18 edges later, quot=4, rem=8, divzero=0.
REQ-026 Signed (macro on), a=-7 (0xFFF9), b=2 -> quot=0xFFFD (-3), rem=0xFFFF (-1); a=7, b=-2 -> quot=0xFFFD, rem=0x0001.
REQ-027 Signed, a=0x8000, b=0xFFFF -> quot=0x8000, rem=0x0000, divzero=0; unsigned same inputs -> quot=0x0000, rem=0x8000.
REQ-028 a=1234, b=0 -> out_finished and divzero high 1 edge after start, quot=0xFFFF, rem=1234.
REQ-029 Start 100/7, assert in_start again at edge 5 with 9/3, pull in_rst low at edge 10 -> second start ignored, all outputs zero immediately on reset, no out_finished; restart 100/7 after release -> quot=14, rem=2 after 18 edges.

Source files
------------

// File: rtl/divider_iter.sv
// divider_iter: iterative restoring radix-2 divider, one quotient bit per cycle.
// Define DIVIDER_ITER_SIGNED_EN to enable two's-complement operation via in_signed.
module divider_iter #(
    parameter int BITS = 16
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_start,
    input  logic            in_signed,
    input  logic [BITS-1:0] in_a,
    input  logic [BITS-1:0] in_b,
    output logic            out_busy,
    output logic            out_finished,
    output logic [BITS-1:0] out_quot,
    output logic [BITS-1:0] out_rem,
    output logic            out_divzero
);
    localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;

    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] prem, quo, div;
    logic [BITS:0]   shifted;
    logic [BITS-1:0] diff;
    logic            fits;
    logic            accept, bzero;
    logic [BITS-1:0] mag_a, mag_b, res_q, res_r;

    assign accept  = in_start && (state == IDLE || state == DONE);
    assign bzero   = (in_b == '0);
    // quotient bit shifts in from the bottom of quo while dividend bits leave its top
    assign shifted = {prem, quo[BITS-1]};
    assign fits    = (shifted >= {1'b0, div});
    assign diff    = shifted[BITS-1:0] - div;

`ifdef DIVIDER_ITER_SIGNED_EN
    logic neg_a, neg_b, qneg, rneg;
    assign neg_a = in_signed & in_a[BITS-1];
    assign neg_b = in_signed & in_b[BITS-1];
    assign mag_a = neg_a ? -in_a : in_a;
    assign mag_b = neg_b ? -in_b : in_b;
    assign res_q = qneg ? -quo : quo;
    assign res_r = rneg ? -prem : prem;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            qneg <= 1'b0;
            rneg <= 1'b0;
        end else if (accept) begin
            qneg <= neg_a ^ neg_b;
            rneg <= neg_a;
        end
    end
`else
    logic unused_signed;
    assign unused_signed = in_signed;
    assign mag_a = in_a;
    assign mag_b = in_b;
    assign res_q = quo;
    assign res_r = prem;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = in_start ? (bzero ? DONE : ITER) : state;
            ITER:       state_nx = (cnt == '0) ? FIXUP : ITER;
            FIXUP:      state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) state <= IDLE;
        else         state <= state_nx;
    end

    assign out_busy     = (state == ITER) || (state == FIXUP);
    assign out_finished = (state == DONE);

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            cnt         <= '0;
            prem        <= '0;
            quo         <= '0;
            div         <= '0;
            out_quot    <= '0;
            out_rem     <= '0;
            out_divzero <= 1'b0;
        end else if (accept) begin
            cnt         <= CW'(BITS - 1);
            prem        <= '0;
            quo         <= mag_a;
            div         <= mag_b;
            out_divzero <= bzero;
            if (bzero) begin
                out_quot <= '1;
                out_rem  <= in_a;
            end
        end else if (state == ITER) begin
            cnt  <= cnt - 1'b1;
            prem <= fits ? diff : shifted[BITS-1:0];
            quo  <= {quo[BITS-2:0], fits};
        end else if (state == FIXUP) begin
            out_quot <= res_q;
            out_rem  <= res_r;
        end
    end
endmodule
